// File: rtl/led_pattern_gen_if.sv
// Control and LED drive bundle for the LED pattern generator.
// Pure wiring, no latency of its own.
// No backpressure: every signal is level-sampled by the consumer each clk.
interface led_pattern_gen_if #(
   parameter int NUM_CH = 3,
   parameter int PRE_W  = 24
);
   logic              enable;
   logic [1:0]        mode;
   logic [PRE_W-1:0]  prescale;
   logic [NUM_CH-1:0] static_mask;
   logic [NUM_CH-1:0] led;
   logic              step;

   // Controller side (switches or register block) drives the controls.
   modport master (
      output enable, mode, prescale, static_mask,
      input  led, step
   );

   // Generator side consumes the controls and drives the LEDs.
   modport slave (
      input  enable, mode, prescale, static_mask,
      output led, step
   );
endinterface

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: COUNT, BREATHE (PWM), CHASE, STATIC.
// led and step are registered: both reflect a tick on the clk edge that consumes it.
// No backpressure; enable=0 freezes all state and blanks the outputs.
module led_pattern_gen #(
   parameter int NUM_CH = 3,
   parameter int PWM_W  = 8,
   parameter int PRE_W  = 24
) (
   input  logic             clk,
   input  logic             reset,
   led_pattern_gen_if.slave bus
);

   typedef enum logic [1:0] {
      M_COUNT   = 2'b00,
      M_BREATHE = 2'b01,
      M_CHASE   = 2'b10,
      M_STATIC  = 2'b11
   } mode_t;

   localparam logic [PWM_W-1:0]  DUTY_MAX   = '1;
   localparam logic [NUM_CH-1:0] CHASE_INIT = {{(NUM_CH-1){1'b0}}, 1'b1};

   logic [PRE_W-1:0]  pre_cnt, pre_cnt_n;
   logic [PWM_W-1:0]  pwm_cnt, pwm_cnt_n;
   logic [PWM_W-1:0]  duty, duty_n;
   logic              dir_down, dir_down_n;
   logic [NUM_CH-1:0] count, count_n;
   logic [NUM_CH-1:0] chase, chase_n;
   logic [NUM_CH-1:0] led_n;
   mode_t             mode_q, mode_n;
   logic              mode_chg;
   logic              tick;

   // Next-state and next-LED computation; a mode change wins over a tick.
   always_comb begin
      mode_n     = mode_t'(bus.mode);
      mode_chg   = (mode_n != mode_q);
      tick       = (pre_cnt == bus.prescale) && !mode_chg;
      // Lowering prescale below pre_cnt lets the counter wrap naturally.
      pre_cnt_n  = (mode_chg || (pre_cnt == bus.prescale)) ? '0 : pre_cnt + 1'b1;
      pwm_cnt_n  = pwm_cnt + 1'b1;
      count_n    = count;
      duty_n     = duty;
      dir_down_n = dir_down;
      chase_n    = chase;
      led_n      = '0;

      if (mode_chg) begin
         count_n    = '0;
         duty_n     = '0;
         dir_down_n = 1'b0;
         chase_n    = CHASE_INIT;
      end else if (tick) begin
         case (mode_n)
            M_COUNT:   count_n = count + 1'b1;
            M_BREATHE: begin
               // Direction flips on reaching an end, so duty never wraps.
               if (!dir_down) begin
                  duty_n     = duty + 1'b1;
                  dir_down_n = (duty_n == DUTY_MAX);
               end else begin
                  duty_n     = duty - 1'b1;
                  dir_down_n = (duty_n != '0);
               end
            end
            M_CHASE:   chase_n = {chase[NUM_CH-2:0], chase[NUM_CH-1]};
            M_STATIC:  ;
         endcase
      end

      case (mode_n)
         M_COUNT:   led_n = count_n;
         M_BREATHE: led_n = {NUM_CH{pwm_cnt_n < duty_n}};
         M_CHASE:   led_n = chase_n;
         M_STATIC:  led_n = bus.static_mask;
      endcase
   end

   // State and output registers; enable=0 holds state (including mode_q, deferring reinit).
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pre_cnt  <= '0;
         pwm_cnt  <= '0;
         count    <= '0;
         duty     <= '0;
         dir_down <= 1'b0;
         chase    <= CHASE_INIT;
         mode_q   <= M_COUNT;
         bus.led  <= '0;
         bus.step <= 1'b0;
      end else if (!bus.enable) begin
         bus.led  <= '0;
         bus.step <= 1'b0;
      end else begin
         pre_cnt  <= pre_cnt_n;
         pwm_cnt  <= pwm_cnt_n;
         count    <= count_n;
         duty     <= duty_n;
         dir_down <= dir_down_n;
         chase    <= chase_n;
         mode_q   <= mode_n;
         bus.led  <= led_n;
         bus.step <= tick;
      end
   end

endmodule

// File: tb/tb_led_pattern_gen.sv
// Self-checking bench for led_pattern_gen (4 channels, 4-bit PWM, 8-bit prescaler).
// Behavioural model compared every cycle, plus directed literal checks.
// Inputs change on negedge; outputs sampled on negedge.
module tb_led_pattern_gen;

   localparam int NUM_CH = 4;
   localparam int PWM_W  = 4;
   localparam int PRE_W  = 8;
   localparam int PWM_LV = 1 << PWM_W;
   localparam int PRE_LV = 1 << PRE_W;
   localparam int CH_LV  = 1 << NUM_CH;

   logic clk = 1'b0;
   logic reset;
   int   n_pass  = 0;
   int   n_total = 0;
   bit   chk_on  = 1'b0;

   led_pattern_gen_if #(.NUM_CH(NUM_CH), .PRE_W(PRE_W)) bus ();

   led_pattern_gen #(.NUM_CH(NUM_CH), .PWM_W(PWM_W), .PRE_W(PRE_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Counts negedges until a step pulse is seen; an expired budget is a failure.
   task automatic wait_step(input int limit, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (bus.step !== 1'b1 && n < limit);
      if (bus.step !== 1'b1) begin
         n_total++;
         $display("FAIL step_timeout: no step within %0d cycles at %0t", limit, $time);
      end
   endtask

   // Behavioural model: integers for counters, chase as a bit position.
   int m_pre = 0, m_pwm = 0, m_count = 0, m_duty = 0, m_pos = 0, m_mode = 0, m_led = 0;
   bit m_up = 1'b1, m_step = 1'b0;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_pre = 0; m_pwm = 0; m_count = 0; m_duty = 0; m_pos = 0; m_mode = 0;
         m_up = 1'b1; m_led = 0; m_step = 1'b0;
      end else if (!bus.enable) begin
         m_led = 0;
         m_step = 1'b0;
      end else begin
         int md;
         bit tk;
         md = int'(bus.mode);
         m_pwm = (m_pwm + 1) % PWM_LV;
         if (md != m_mode) begin
            m_mode = md; m_pre = 0; m_count = 0; m_duty = 0; m_up = 1'b1; m_pos = 0;
            m_step = 1'b0;
         end else begin
            tk = (m_pre == int'(bus.prescale));
            m_pre = tk ? 0 : (m_pre + 1) % PRE_LV;
            m_step = tk;
            if (tk) begin
               if (md == 0) m_count = (m_count + 1) % CH_LV;
               else if (md == 1) begin
                  if (m_up) begin
                     m_duty++;
                     if (m_duty == PWM_LV - 1) m_up = 1'b0;
                  end else begin
                     m_duty--;
                     if (m_duty == 0) m_up = 1'b1;
                  end
               end else if (md == 2) m_pos = (m_pos + 1) % NUM_CH;
            end
         end
         if (md == 0)      m_led = m_count;
         else if (md == 1) m_led = (m_pwm < m_duty) ? CH_LV - 1 : 0;
         else if (md == 2) m_led = 1 << m_pos;
         else              m_led = int'(bus.static_mask);
      end
   end

   // Per-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (chk_on) begin
         check("model_led", 32'(bus.led), 32'(m_led));
         check("model_step", 32'(bus.step), 32'(m_step));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int n, hi;
      reset = 1'b1;
      bus.enable = 1'b0;
      bus.mode = 2'b00;
      bus.prescale = 8'd3;
      bus.static_mask = '0;
      chk_on = 1'b1;
      @(negedge clk); @(negedge clk);
      check("reset_led", 32'(bus.led), 0);
      check("reset_step", 32'(bus.step), 0);

      // Reset release: first tick after prescale+1 cycles, then periodic.
      reset = 1'b0; bus.enable = 1'b1;
      wait_step(20, n); check("first_step_latency", n, 4); check("first_step_led", 32'(bus.led), 4'b0001);
      wait_step(20, n); check("step_period", n, 4); check("second_step_led", 32'(bus.led), 4'b0010);

      // Asynchronous reset mid-cycle clears outputs immediately.
      #2 reset = 1'b1;
      #1 check("async_rst_led", 32'(bus.led), 0); check("async_rst_step", 32'(bus.step), 0);
      @(negedge clk); bus.prescale = 8'd1; reset = 1'b0;

      // COUNT: led changes together with each step, wrapping 1111 -> 0000.
      for (int k = 1; k <= 16; k++) begin
         wait_step(10, n);
         check("count_gap", n, 2);
         check("count_led", 32'(bus.led), k % 16);
      end

      // Prescale lowered below pre_cnt (6): counter wraps through 255 before ticking.
      bus.prescale = 8'd9;
      repeat (6) @(negedge clk);
      bus.prescale = 8'd2;
      wait_step(400, n); check("wrap_latency", n, 253);
      wait_step(10, n); check("wrap_period", n, 3);

      // BREATHE: duty 0 is dark; freeze at duty 5, then count PWM high cycles.
      bus.mode = 2'b01; bus.prescale = 8'd0;
      @(negedge clk); check("breathe_duty0_led", 32'(bus.led), 0);
      repeat (5) @(negedge clk);
      bus.enable = 1'b0; bus.prescale = 8'd200;
      repeat (3) @(negedge clk);
      check("freeze_led", 32'(bus.led), 0); check("freeze_step", 32'(bus.step), 0);
      bus.enable = 1'b1; hi = 0;
      repeat (16) begin
         @(negedge clk);
         if (bus.led == 4'hF) hi++;
      end
      check("pwm_high_cycles", hi, 5);
      bus.prescale = 8'd0;
      repeat (300) @(negedge clk);

      // STATIC: mask follows input every cycle.
      bus.mode = 2'b11; bus.static_mask = 4'b0101;
      @(negedge clk); check("static_led", 32'(bus.led), 4'b0101);
      bus.static_mask = 4'b1010;
      @(negedge clk); check("static_resample", 32'(bus.led), 4'b1010);
      bus.prescale = 8'd2;
      repeat (4) @(negedge clk);

      // CHASE after mid-period switch: init pattern next cycle, rotation every 3.
      bus.mode = 2'b10;
      @(negedge clk); check("chase_init_led", 32'(bus.led), 4'b0001);
      for (int j = 1; j <= 4; j++) begin
         wait_step(10, n);
         check("chase_gap", n, 3);
         check("chase_led", 32'(bus.led), 1 << (j % 4));
      end

      // Enable gating in COUNT with pre_cnt held at 2 of 3.
      bus.mode = 2'b00; bus.prescale = 8'd3;
      for (int k = 1; k <= 5; k++) begin
         wait_step(10, n);
         check("gate_count_led", 32'(bus.led), k);
      end
      repeat (2) @(negedge clk);
      bus.enable = 1'b0;
      repeat (10) begin
         @(negedge clk);
         check("gated_led", 32'(bus.led), 0);
         check("gated_step", 32'(bus.step), 0);
      end
      bus.enable = 1'b1;
      @(negedge clk); check("resume_led", 32'(bus.led), 4'b0101); check("resume_step", 32'(bus.step), 0);
      @(negedge clk); check("resume_tick_led", 32'(bus.led), 4'b0110); check("resume_tick_step", 32'(bus.step), 1);

      // Mode change while disabled takes effect only once enable returns.
      bus.enable = 1'b0; bus.mode = 2'b10;
      repeat (3) @(negedge clk); check("deferred_led", 32'(bus.led), 0);
      bus.enable = 1'b1;
      @(negedge clk); check("deferred_chg_led", 32'(bus.led), 4'b0001); check("deferred_chg_step", 32'(bus.step), 0);
      repeat (10) @(negedge clk);

      chk_on = 1'b0;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/led_pattern_gen.md
Name: led_pattern_gen

Overview:
- Parametrised multi-channel LED pattern generator; successor to the single-mode free-running LED divider.
- Drives NUM_CH board LEDs from the system clock.
- Runtime-selectable mode: binary count, PWM breathe, one-hot chase, static mask.
- Programmable step rate via an internal prescaler. Sits between top-level clock/reset and the LED pins; control inputs come from switches or a register block.

Parameters:
- NUM_CH, 3, number of LED channels (>=2); bit 0 = Green, 1 = Red, 2 = Blue on the current board.
- PWM_W, 8, PWM counter and duty width in bits.
- PRE_W, 24, prescaler width in bits.

Ports:
- clk  input  1  system clock (hw_clk).
- reset  input  1  asynchronous, active-high reset.
- enable  input  1  1 = run; 0 = freeze all state and blank the LEDs.
- mode  input  2  00 COUNT, 01 BREATHE, 10 CHASE, 11 STATIC.
- prescale  input  PRE_W  step period minus 1, in clk cycles.
- static_mask  input  NUM_CH  LED pattern used in STATIC mode.
- led  output  NUM_CH  registered LED drive, active-high.
- step  output  1  registered one-cycle pulse per pattern step.

Behaviour:
- Reset: clears pre_cnt, pwm_cnt, count, duty and step; sets led=0, dir=up, chase=1 (one-hot bit 0), mode_q=00.
- Prescaler:
  - When enable=1: pre_cnt increments each clk.
  - When pre_cnt == prescale: pre_cnt returns to 0 and an internal tick asserts for that cycle.
  - prescale=0 gives a tick every cycle.
  - If prescale is lowered below pre_cnt, the counter wraps at 2^PRE_W and then ticks normally; no lock-up.
  - step = tick registered, so step has 1 cycle of latency.
- PWM counter: PWM_W bits, free-running +1 per clk while enable=1, wraps naturally.
- COUNT mode: count (NUM_CH bits) +1 on tick, wraps from all-ones to 0; led[i] <= count[i].
- BREATHE mode:
  - duty (PWM_W bits) steps on tick: +1 when dir=up, -1 when dir=down.
  - When duty reaches 2^PWM_W-1 on an up step, dir flips to down. When it reaches 0 on a down step, dir flips to up. Duty therefore never wraps.
  - All channels: led[i] <= (pwm_cnt < duty). duty=0 gives LEDs always off; max duty gives off for 1 of 2^PWM_W cycles.
- CHASE mode:
  - One-hot chase register rotates left on tick; the MSB returns to bit 0.
  - led <= chase.
- STATIC mode: led <= static_mask, sampled every clk; tick is ignored for the pattern.
- Mode change:
  - mode_q registers mode each clk.
  - On any cycle where mode != mode_q, the pattern state is re-initialised: count=0, duty=0, dir=up, chase=1. The prescaler is also cleared, and any tick in that cycle is discarded.
  - led shows the new mode's initial pattern 1 cycle later.
- enable=0:
  - pre_cnt, pwm_cnt, count, duty, dir and chase all hold.
  - led <= 0 and step <= 0 on the next clk.
  - When enable returns to 1, operation resumes from the held state with no reinitialisation.
- Output latency: led reflects internal state with 1 registered cycle of delay. led, step and all state are updated only on posedge clk, except under asynchronous reset.
- Reset mid-operation: all outputs go to their reset values immediately (asynchronously). The first tick after reset release occurs prescale+1 cycles later.
- Simultaneous events:
  - Mode change overrides tick.
  - enable=0 overrides tick and mode-change reinitialisation, which is deferred until enable=1.

Test Plan:
- Reset check: NUM_CH=3, assert reset mid-run -> led=000 and step=0 in the same cycle. With mode=00, prescale=3, enable=1 after release -> first step pulse 4 cycles after release, then every 4 cycles.
- COUNT mode: prescale=1, 16 steps -> led sequence 000,001,010,...,111,000,...; each led change follows its step pulse by 0 cycles (both registered from the same tick).
- BREATHE mode: PWM_W=4, prescale=0 -> duty ramps 0..15..0. Over a 16-cycle PWM window with duty held at 5 (enable toggled to freeze), led high for exactly 5 cycles. At duty=0, led stays 000.
- CHASE mode: NUM_CH=4, prescale=2 -> led 0001,0010,0100,1000,0001, advancing every 3 cycles.
- STATIC mode and mode change: mode=11, static_mask=101 -> led=101 one cycle later. Switch to 10 mid-period -> led=001 the next cycle; the first rotation comes prescale+1 cycles after the switch.
- Enable gating: in COUNT mode, drop enable at count=5 for 10 cycles -> led=000 and no step pulses. Raise enable -> led=101, and count resumes toward 6 with the held pre_cnt.
